seg_scan_capture: RTL and testbench

- Receive-side counterpart of the multiplexed seven-segment display driver (anode/cathode bus).
- Monitors an active-low, one-hot anode strobe and an active-low 7-bit cathode bus, and debounces each digit dwell.
- Decodes the cathode pattern back to a hex nibble and assembles complete 4-digit frames.
- Used as a self-checking observer in display benches, and in-fabric for loopback of display output into logic.

---
 rtl/seg_scan_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 34 +++
 rtl/seg_scan_capture.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_capture.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and cathode codes for the seven-segment scan capture.
// Cathode codes are active-low {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0100000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {SCAN, COMMIT} scan_state_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       ok;
  } seg_dec_t;

  // True when exactly one anode bit is low.
  function automatic logic one_low(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) ||
           (a == 4'b1011) || (a == 4'b0111);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational cathode-pattern to hex-nibble decoder.
// Ports: cathode (active-low segments) in, dec {nib,blank,ok} out.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] cathode,
  output seg_dec_t   dec
);

  always_comb begin
    dec = '{nib: 4'h0, blank: 1'b0, ok: 1'b1};
    unique case (cathode)
      SEG_0:     dec.nib = 4'h0;
      SEG_1:     dec.nib = 4'h1;
      SEG_2:     dec.nib = 4'h2;
      SEG_3:     dec.nib = 4'h3;
      SEG_4:     dec.nib = 4'h4;
      SEG_5:     dec.nib = 4'h5;
      SEG_6:     dec.nib = 4'h6;
      SEG_7:     dec.nib = 4'h7;
      SEG_8:     dec.nib = 4'h8;
      SEG_9:     dec.nib = 4'h9;
      SEG_A:     dec.nib = 4'hA;
      SEG_B:     dec.nib = 4'hB;
      SEG_C:     dec.nib = 4'hC;
      SEG_D:     dec.nib = 4'hD;
      SEG_E:     dec.nib = 4'hE;
      SEG_F:     dec.nib = 4'hF;
      SEG_BLANK: dec.blank = 1'b1;
      default:   dec.ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Debounces a multiplexed 7-seg anode/cathode bus and rebuilds 4-digit frames.
// Ports: clk, rst (async low), anode, cathode, err_clr -> digits, blank, frame_done, seg_err, anode_err, scan_timeout.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter  int STABLE_CYCLES  = 4,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anode,
  input  logic [6:0]  cathode,
  input  logic        err_clr,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        frame_done,
  output logic        seg_err,
  output logic        anode_err,
  output logic        scan_timeout
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic [10:0]      prev;
  logic [SW-1:0]    stab_cnt;
  logic             accepted;
  logic             same;
  logic             accept;
  seg_dec_t         dec;
  logic             hot;
  logic             take;
  logic             bad_seg;
  logic             bad_an;
  logic [3:0]       sel;
  logic [3:0]       seen;
  logic [3:0]       seen_nxt;
  logic [15:0]      part_nib;
  logic [15:0]      part_nib_nxt;
  logic [3:0]       part_blank;
  logic [3:0]       part_blank_nxt;
  logic             done_nxt;
  logic [CNT_W-1:0] tcnt;
  scan_state_t      state;
  scan_state_t      state_nxt;

  seg7_decode u_dec (
    .cathode (cathode),
    .dec     (dec)
  );

  assign same   = ({anode, cathode} == prev);
  assign accept = same && !accepted &&
                  (stab_cnt == SW'(STABLE_CYCLES - 1));
  assign hot     = one_low(anode);
  assign sel     = ~anode;
  assign take    = accept && hot && dec.ok;
  assign bad_seg = accept && hot && !dec.ok;
  assign bad_an  = accept && (anode != 4'hF) && !hot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= {4'hF, 7'h7F};
      stab_cnt <= '0;
      accepted <= 1'b0;
    end else begin
      prev <= {anode, cathode};
      if (!same) begin
        stab_cnt <= SW'(1);
        accepted <= 1'b0;
      end else begin
        if (stab_cnt != SW'(STABLE_CYCLES))
          stab_cnt <= stab_cnt + SW'(1);
        if (accept)
          accepted <= 1'b1;
      end
    end
  end

  // COMMIT starts a fresh frame before any same-cycle accept lands.
  always_comb begin
    seen_nxt = (state == COMMIT) ? 4'h0 : seen;
    if (take)
      seen_nxt = seen_nxt | sel;
  end

  always_comb begin
    part_nib_nxt   = part_nib;
    part_blank_nxt = part_blank;
    for (int k = 0; k < 4; k++) begin
      if (take && sel[k]) begin
        part_nib_nxt[4*k +: 4] = dec.nib;
        part_blank_nxt[k]      = dec.blank;
      end
    end
  end

  assign done_nxt = (state == SCAN) && (seen_nxt == 4'hF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= SCAN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SCAN:    if (done_nxt) state_nxt = COMMIT;
      COMMIT:  state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  always_comb begin
    frame_done = (state == COMMIT);
  end

  // Outputs load on the completing edge so they are valid with frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen       <= '0;
      part_nib   <= '0;
      part_blank <= '0;
      digits     <= '0;
      blank      <= '0;
    end else begin
      seen       <= seen_nxt;
      part_nib   <= part_nib_nxt;
      part_blank <= part_blank_nxt;
      if (done_nxt) begin
        digits <= part_nib_nxt;
        blank  <= part_blank_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tcnt <= '0;
    else if (state == COMMIT)
      tcnt <= '0;
    else if (tcnt != CNT_W'(TIMEOUT_CYCLES))
      tcnt <= tcnt + CNT_W'(1);
  end

  assign scan_timeout = (tcnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_err   <= 1'b0;
      anode_err <= 1'b0;
    end else begin
      if (bad_seg)      seg_err <= 1'b1;
      else if (err_clr) seg_err <= 1'b0;
      if (bad_an)       anode_err <= 1'b1;
      else if (err_clr) anode_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture.
// Expected frames are queued on stimulus and popped on frame_done.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  anode = 4'hF;
  logic [6:0]  cathode = 7'h7F;
  logic        err_clr = 1'b0;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_done;
  logic        seg_err;
  logic        anode_err;
  logic        scan_timeout;

  int checks = 0;
  int failures = 0;
  int frames = 0;
  int f0;
  logic [19:0] sb[$];

  seg_scan_capture dut (
    .clk          (clk),
    .rst          (rst),
    .anode        (anode),
    .cathode      (cathode),
    .err_clr      (err_clr),
    .digits       (digits),
    .blank        (blank),
    .frame_done   (frame_done),
    .seg_err      (seg_err),
    .anode_err    (anode_err),
    .scan_timeout (scan_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 16 selects the blank pattern.
  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0100000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic dwell(input logic [3:0] a, input logic [6:0] c,
                       input int n);
    anode   = a;
    cathode = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int d3, input int d2,
                       input int d1, input int d0);
    dwell(4'b0111, seg_of(d3), 8);
    dwell(4'b1011, seg_of(d2), 8);
    dwell(4'b1101, seg_of(d1), 8);
    dwell(4'b1110, seg_of(d0), 8);
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    anode   = 4'hF;
    cathode = 7'h7F;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && frame_done) begin
      frames++;
      if (sb.size() == 0) begin
        chk("frame_unexp", 1, 0);
      end else begin
        logic [19:0] e;
        e = sb.pop_front();
        chk("sb_digits", {16'h0, digits}, {16'h0, e[19:4]});
        chk("sb_blank", {28'h0, blank}, {28'h0, e[3:0]});
      end
    end
  end

  initial begin
    do_reset();
    chk("rst_digits", {16'h0, digits}, 0);
    chk("rst_blank", {28'h0, blank}, 0);
    chk("rst_fd", {31'h0, frame_done}, 0);
    chk("rst_errs", {30'h0, seg_err, anode_err}, 0);
    chk("rst_to", {31'h0, scan_timeout}, 0);

    // plain frame
    sb.push_back({16'h1234, 4'h0});
    frame(1, 2, 3, 4);
    chk("t1_errs", {30'h0, seg_err, anode_err}, 0);
    chk("t1_frames", frames, 1);

    // short glitch inside a dwell
    sb.push_back({16'h1234, 4'h0});
    dwell(4'b0111, seg_of(1), 8);
    dwell(4'b1011, seg_of(2), 8);
    dwell(4'b1101, seg_of(3), 3);
    dwell(4'b1101, 7'b0000000, 2);
    dwell(4'b1101, seg_of(3), 8);
    dwell(4'b1110, seg_of(4), 8);
    chk("t2_seg_err", {31'h0, seg_err}, 0);
    chk("t2_frames", frames, 2);

    // undecodable pattern
    f0 = frames;
    dwell(4'b1110, 7'b1010101, 8);
    chk("t3_seg_err", {31'h0, seg_err}, 1);
    dwell(4'hF, 7'h7F, 2);
    chk("t3_no_frame", frames, f0);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("t3_clr", {31'h0, seg_err}, 0);

    // multi-low anode, then frame with a blank
    dwell(4'b0011, seg_of(8), 8);
    chk("t4_anode_err", {31'h0, anode_err}, 1);
    sb.push_back({16'hEF00, 4'b0010});
    frame(14, 15, 16, 0);
    chk("t4_sticky", {31'h0, anode_err}, 1);
    chk("t4_seg_err", {31'h0, seg_err}, 0);

    // timeout
    do_reset();
    repeat (4095) @(posedge clk);
    #1;
    chk("t5_to_4095", {31'h0, scan_timeout}, 0);
    @(posedge clk);
    #1;
    chk("t5_to_4096", {31'h0, scan_timeout}, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_to_hold", {31'h0, scan_timeout}, 1);
    sb.push_back({16'h5678, 4'h0});
    dwell(4'b0111, seg_of(5), 8);
    dwell(4'b1011, seg_of(6), 8);
    dwell(4'b1101, seg_of(7), 8);
    dwell(4'b1110, seg_of(8), 4);
    chk("t5_fd", {31'h0, frame_done}, 1);
    chk("t5_to_commit", {31'h0, scan_timeout}, 1);
    dwell(4'b1110, seg_of(8), 1);
    chk("t5_to_clear", {31'h0, scan_timeout}, 0);
    dwell(4'b1110, seg_of(8), 3);

    // reset mid-frame
    dwell(4'b0111, seg_of(3), 8);
    dwell(4'b1011, seg_of(2), 8);
    #2;
    rst = 1'b0;
    anode = 4'hF;
    cathode = 7'h7F;
    #3;
    chk("t6_rst_digits", {16'h0, digits}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    f0 = frames;
    sb.push_back({16'h9876, 4'h0});
    frame(9, 8, 7, 6);
    dwell(4'hF, 7'h7F, 4);
    chk("t6_one_frame", frames, f0 + 1);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
